// File: rtl/tracker_pkg.sv
// Shared types and constants for the colour-blob tracker.
package tracker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

  localparam logic [1:0] DIR_NONE   = 2'b00;
  localparam logic [1:0] DIR_LEFT   = 2'b01;
  localparam logic [1:0] DIR_CENTRE = 2'b10;
  localparam logic [1:0] DIR_RIGHT  = 2'b11;

  localparam int PERS_W = 4;

  // Saturating persistence step: count up on a seen frame, clear otherwise.
  function automatic logic [PERS_W-1:0] persist_next(input logic [PERS_W-1:0] cur,
                                                     input logic              seen,
                                                     input logic [PERS_W-1:0] limit);
    logic [PERS_W-1:0] nxt;
    if (!seen) begin
      nxt = 4'd0;
    end else if (cur >= limit) begin
      nxt = limit;
    end else begin
      nxt = cur + 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle. start performs the first
// step immediately, so a full division takes exactly SUM_W cycles and done
// is a one-cycle pulse in the cycle after the last step.
module seq_divider #(
  parameter int SUM_W = 28,
  parameter int CNT_W = 19,
  parameter int Q_W   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [SUM_W-1:0] dividend_i,
  input  logic [CNT_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Q_W-1:0]   quotient_o
);

  localparam int CW = $clog2(SUM_W + 1);

  logic [CNT_W-1:0] rem_q, rem_d, src_rem_s, rem_step_s;
  logic [SUM_W-1:0] quo_q, quo_d, src_quo_s, quo_step_s;
  logic [CNT_W-1:0] div_q, div_d, src_div_s;
  logic             zero_q, zero_d, src_zero_s;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [CNT_W:0]   shifted_s;
  logic             fits_s;

  // One restoring step on either the freshly loaded operands or the running state.
  always_comb begin
    src_rem_s  = start_i ? {CNT_W{1'b0}} : rem_q;
    src_quo_s  = start_i ? dividend_i : quo_q;
    src_div_s  = start_i ? divisor_i : div_q;
    src_zero_s = start_i ? (divisor_i == {CNT_W{1'b0}}) : zero_q;
    shifted_s  = {src_rem_s, src_quo_s[SUM_W-1]};
    fits_s     = shifted_s >= {1'b0, src_div_s};
    if (fits_s) begin
      rem_step_s = CNT_W'(shifted_s - {1'b0, src_div_s});
    end else begin
      rem_step_s = shifted_s[CNT_W-1:0];
    end
    quo_step_s = {src_quo_s[SUM_W-2:0], fits_s};
  end

  // Next-state: load on start, iterate while busy, pulse done after the last bit.
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    div_d  = div_q;
    zero_d = zero_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start_i) begin
      div_d  = divisor_i;
      zero_d = src_zero_s;
      rem_d  = rem_step_s;
      quo_d  = src_zero_s ? {SUM_W{1'b0}} : quo_step_s;
      cnt_d  = CW'(SUM_W - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = rem_step_s;
      quo_d = zero_q ? {SUM_W{1'b0}} : quo_step_s;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      zero_q <= 1'b0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      div_q  <= div_d;
      zero_q <= zero_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign quotient_o = quo_q[Q_W-1:0];

endmodule

// File: rtl/blob_tracker.sv
// Per-class colour blob tracker: accumulates hit count and x sum per frame,
// divides them into a centroid after each vsync falling edge, classifies the
// centroid into left/centre/right and filters detection over frames.
module blob_tracker
  import tracker_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int N_CLASS   = 2,
  parameter int MIN_COUNT = 256,
  parameter int PERSIST   = 3,
  parameter int ZONE_L    = 213,
  parameter int ZONE_R    = 426
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            pixel_valid,
  input  logic                                            vsync,
  input  logic [N_CLASS-1:0]                              class_hit,
  output logic                                            result_valid,
  output logic [N_CLASS*$clog2(H_ACTIVE)-1:0]             centroid_x,
  output logic [N_CLASS*$clog2(H_ACTIVE*V_ACTIVE+1)-1:0]  pix_count,
  output logic [N_CLASS*2-1:0]                            direction,
  output logic [N_CLASS-1:0]                              detected,
  output logic                                            overrun
);

  localparam int X_W   = $clog2(H_ACTIVE);
  localparam int CNT_W = $clog2(H_ACTIVE * V_ACTIVE + 1);
  localparam int SUM_W = $clog2(H_ACTIVE * V_ACTIVE * H_ACTIVE);
  localparam int CLS_W = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;

  state_e             state_q, state_d;
  logic               vs_q, frame_end_s;
  logic [X_W-1:0]     x_q;
  logic               line_full_q, pix_ok_s;
  logic [CNT_W-1:0]   acc_cnt_q  [N_CLASS];
  logic [SUM_W-1:0]   acc_sum_q  [N_CLASS];
  logic [CNT_W-1:0]   snap_cnt_q [N_CLASS];
  logic [SUM_W-1:0]   snap_sum_q [N_CLASS];
  logic [X_W-1:0]     quo_q      [N_CLASS];
  logic [CLS_W-1:0]   cls_q, op_idx_s;
  logic               launch_q, last_cls_s, start_s;
  logic               div_busy_s, div_done_s;
  logic [X_W-1:0]     div_quo_s;
  logic [PERS_W-1:0]  pers_q     [N_CLASS];
  logic [PERS_W-1:0]  pers_d     [N_CLASS];
  logic [1:0]         dir_d      [N_CLASS];
  logic [N_CLASS-1:0] seen_s;
  logic [X_W-1:0]     cent_q     [N_CLASS];
  logic [CNT_W-1:0]   cnt_out_q  [N_CLASS];
  logic [1:0]         dir_q      [N_CLASS];
  logic [N_CLASS-1:0] det_q;
  logic               rv_q, ovr_q;

  assign frame_end_s = vs_q & ~vsync;
  assign pix_ok_s    = pixel_valid & ~line_full_q;
  assign last_cls_s  = (cls_q == CLS_W'(N_CLASS - 1));
  assign start_s     = (state_q == ST_DIVIDE) && !div_busy_s &&
                       (launch_q || (div_done_s && !last_cls_s));
  // Class 0 is loaded on launch; later classes start as the previous one finishes.
  assign op_idx_s    = launch_q ? cls_q : cls_q + CLS_W'(1);

  // vsync edge sampler; idles high so reset release never looks like a frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vs_q <= 1'b1;
    else        vs_q <= vsync;
  end

  // Column counter: counts active pixels, stops at the last column, clears between lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      line_full_q <= 1'b0;
    end else if (!pixel_valid) begin
      x_q         <= '0;
      line_full_q <= 1'b0;
    end else if (x_q == X_W'(H_ACTIVE - 1)) begin
      line_full_q <= 1'b1;
    end else begin
      x_q <= x_q + X_W'(1);
    end
  end

  // Per-class accumulators; frame end clears them and wins over a same-cycle hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CLASS; i++) begin
        acc_cnt_q[i] <= '0;
        acc_sum_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CLASS; i++) begin
        if (frame_end_s) begin
          acc_cnt_q[i] <= '0;
          acc_sum_q[i] <= '0;
        end else if (pix_ok_s && class_hit[i]) begin
          acc_cnt_q[i] <= acc_cnt_q[i] + CNT_W'(1);
          acc_sum_q[i] <= acc_sum_q[i] + SUM_W'(x_q);
        end
      end
    end
  end

  // Snapshot only when idle so a late frame end never corrupts a running division.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CLASS; i++) begin
        snap_cnt_q[i] <= '0;
        snap_sum_q[i] <= '0;
      end
    end else if (frame_end_s && state_q == ST_IDLE) begin
      for (int i = 0; i < N_CLASS; i++) begin
        snap_cnt_q[i] <= acc_cnt_q[i];
        snap_sum_q[i] <= acc_sum_q[i];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = frame_end_s ? ST_DIVIDE : ST_IDLE;
      ST_DIVIDE: state_d = (div_done_s && last_cls_s) ? ST_UPDATE : ST_DIVIDE;
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Class sequencing and quotient capture during DIVIDE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_q    <= '0;
      launch_q <= 1'b0;
      for (int i = 0; i < N_CLASS; i++) quo_q[i] <= '0;
    end else if (state_q == ST_IDLE) begin
      if (frame_end_s) begin
        cls_q    <= '0;
        launch_q <= 1'b1;
      end
    end else if (state_q == ST_DIVIDE) begin
      if (start_s) launch_q <= 1'b0;
      if (div_done_s) begin
        quo_q[cls_q] <= div_quo_s;
        if (!last_cls_s) cls_q <= cls_q + CLS_W'(1);
      end
    end
  end

  seq_divider #(
    .SUM_W (SUM_W),
    .CNT_W (CNT_W),
    .Q_W   (X_W)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_s),
    .dividend_i (snap_sum_q[op_idx_s]),
    .divisor_i  (snap_cnt_q[op_idx_s]),
    .busy_o     (div_busy_s),
    .done_o     (div_done_s),
    .quotient_o (div_quo_s)
  );

  // Classification of each class result and its next persistence count.
  always_comb begin
    for (int i = 0; i < N_CLASS; i++) begin
      seen_s[i] = (snap_cnt_q[i] >= CNT_W'(MIN_COUNT));
      if (!seen_s[i]) begin
        dir_d[i] = DIR_NONE;
      end else if (quo_q[i] < X_W'(ZONE_L)) begin
        dir_d[i] = DIR_LEFT;
      end else if (quo_q[i] >= X_W'(ZONE_R)) begin
        dir_d[i] = DIR_RIGHT;
      end else begin
        dir_d[i] = DIR_CENTRE;
      end
      pers_d[i] = persist_next(pers_q[i], seen_s[i], PERS_W'(PERSIST));
    end
  end

  // Output registers: refreshed only in UPDATE, held otherwise; pulses default low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv_q  <= 1'b0;
      ovr_q <= 1'b0;
      det_q <= '0;
      for (int i = 0; i < N_CLASS; i++) begin
        cent_q[i]    <= '0;
        cnt_out_q[i] <= '0;
        dir_q[i]     <= DIR_NONE;
        pers_q[i]    <= '0;
      end
    end else begin
      rv_q  <= (state_q == ST_UPDATE);
      ovr_q <= frame_end_s && (state_q != ST_IDLE);
      if (state_q == ST_UPDATE) begin
        for (int i = 0; i < N_CLASS; i++) begin
          cent_q[i]    <= quo_q[i];
          cnt_out_q[i] <= snap_cnt_q[i];
          dir_q[i]     <= dir_d[i];
          pers_q[i]    <= pers_d[i];
          det_q[i]     <= (pers_d[i] == PERS_W'(PERSIST));
        end
      end
    end
  end

  for (genvar g = 0; g < N_CLASS; g++) begin : g_out
    assign centroid_x[g*X_W +: X_W]   = cent_q[g];
    assign pix_count[g*CNT_W +: CNT_W] = cnt_out_q[g];
    assign direction[g*2 +: 2]        = dir_q[g];
  end

  assign detected     = det_q;
  assign result_valid = rv_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_blob_tracker.sv
// Scoreboard bench for blob_tracker (default parameters, two classes).
module tb_blob_tracker;

  localparam int unsigned LAT = 58;  // 2 classes * 28 divider cycles + 2

  typedef struct {
    int unsigned when;
    logic [37:0] cnt;
    logic [19:0] cent;
    logic [3:0]  dir;
    logic [1:0]  det;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pixel_valid;
  logic        vsync;
  logic [1:0]  class_hit;
  logic        result_valid;
  logic [19:0] centroid_x;
  logic [37:0] pix_count;
  logic [3:0]  direction;
  logic [1:0]  detected;
  logic        overrun;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  exp_t        exp_q[$];
  int unsigned ovr_q[$];
  exp_t        mon_e;
  exp_t        e7;

  blob_tracker dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pixel_valid  (pixel_valid),
    .vsync        (vsync),
    .class_hit    (class_hit),
    .result_valid (result_valid),
    .centroid_x   (centroid_x),
    .pix_count    (pix_count),
    .direction    (direction),
    .detected     (detected),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t mk(int n0, int c0, int d0, int t0, int n1, int c1, int d1, int t1);
    exp_t e;
    e.when = 0;
    e.cnt  = {19'(n1), 19'(n0)};
    e.cent = {10'(c1), 10'(c0)};
    e.dir  = {2'(d1), 2'(d0)};
    e.det  = {1'(t1), 1'(t0)};
    return e;
  endfunction

  // One 640-pixel line; class i hits where lo_i <= x <= hi_i (-1,-1 = none).
  task automatic drive_line(input int lo0, input int hi0, input int lo1, input int hi1);
    for (int x = 0; x < 640; x++) begin
      pixel_valid = 1'b1;
      class_hit   = {(x >= lo1 && x <= hi1), (x >= lo0 && x <= hi0)};
      @(negedge clk);
    end
    pixel_valid = 1'b0;
    class_hit   = 2'b00;
    repeat (4) @(negedge clk);
  endtask

  task automatic end_frame(input exp_t e, input bit push, input bit edge_hit);
    vsync       = 1'b0;
    pixel_valid = edge_hit;
    class_hit   = edge_hit ? 2'b01 : 2'b00;
    e.when      = cyc + 1 + LAT;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    pixel_valid = 1'b0;
    class_hit   = 2'b00;
    repeat (2) @(negedge clk);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_frame(input int a0l, input int a0h, input int a1l, input int a1h,
                           input int b0l, input int b0h, input int b1l, input int b1h,
                           input exp_t e);
    drive_line(a0l, a0h, a1l, a1h);
    drive_line(b0l, b0h, b1l, b1h);
    end_frame(e, 1'b1, 1'b0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_result_valid"}, 64'(result_valid), 0);
    chk({tag, "_centroid"},     64'(centroid_x), 0);
    chk({tag, "_pix_count"},    64'(pix_count), 0);
    chk({tag, "_direction"},    64'(direction), 0);
    chk({tag, "_detected"},     64'(detected), 0);
    chk({tag, "_overrun"},      64'(overrun), 0);
  endtask

  // Monitor: every result_valid / overrun pulse must match the next expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result_valid: got pulse expected none (cycle %0d)", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("latency",    64'(cyc), 64'(mon_e.when));
          chk("pix_count",  64'(pix_count), 64'(mon_e.cnt));
          chk("centroid_x", 64'(centroid_x), 64'(mon_e.cent));
          chk("direction",  64'(direction), 64'(mon_e.dir));
          chk("detected",   64'(detected), 64'(mon_e.det));
        end
      end
      if (overrun) begin
        if (ovr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_overrun: got pulse expected none (cycle %0d)", cyc);
        end else begin
          chk("overrun_cycle", 64'(cyc), 64'(ovr_q.pop_front()));
        end
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    vsync       = 1'b1;
    pixel_valid = 1'b0;
    class_hit   = 2'b00;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // F1: c0 300 hits mean 100 (left), c1 400 hits mean 500 (right)
    run_frame(0, 200, 361, 639, 51, 149, 440, 560, mk(300, 100, 1, 0, 400, 500, 3, 0));
    // F2: c0 100 hits mean 320 (below MIN_COUNT), c1 second seen frame
    run_frame(300, 340, 361, 639, 291, 349, 440, 560, mk(100, 320, 0, 0, 400, 500, 3, 0));
    // F3: c0 empty (divide by zero), c1 third seen frame -> detected
    run_frame(-1, -1, 361, 639, -1, -1, 440, 560, mk(0, 0, 0, 0, 400, 500, 3, 1));
    // F4: c0 centre at 320, c1 empty -> detection drops
    run_frame(220, 420, -1, -1, 271, 369, -1, -1, mk(300, 320, 2, 0, 0, 0, 0, 0));
    // F5: zone boundaries, c0 mean 213 (centre), c1 mean 426 (right)
    run_frame(113, 313, 326, 526, 164, 262, 377, 475, mk(300, 213, 2, 0, 300, 426, 3, 0));
    // F6: MIN_COUNT boundary: c0 256 hits (seen, 3rd in a row), c1 255 hits (unseen)
    run_frame(0, 255, 0, 254, -1, -1, -1, -1, mk(256, 127, 1, 1, 255, 127, 0, 0));

    // Reset in the middle of a division: outputs clear, no result follows.
    drive_line(0, 200, 361, 639);
    drive_line(51, 149, 440, 560);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
    vsync = 1'b1;
    repeat (18) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("mid_divide_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);

    // F7 plus a second frame end 10 cycles later while dividing.
    drive_line(0, 200, -1, -1);
    drive_line(51, 149, -1, -1);
    e7      = mk(300, 100, 1, 0, 0, 0, 0, 0);
    vsync   = 1'b0;
    e7.when = cyc + 1 + LAT;
    exp_q.push_back(e7);
    repeat (2) @(negedge clk);
    vsync       = 1'b1;
    pixel_valid = 1'b1;
    class_hit   = 2'b11;
    repeat (5) @(negedge clk);
    pixel_valid = 1'b0;
    class_hit   = 2'b00;
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    ovr_q.push_back(cyc + 1);
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    repeat (80) @(negedge clk);

    // F8: discarded hits are gone and the hit on the frame-end cycle is lost.
    end_frame(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1);
    repeat (80) @(negedge clk);
    // F9: the lost hit does not reappear in the following frame either.
    end_frame(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
    repeat (100) @(negedge clk);

    chk("results_outstanding", 64'(exp_q.size()), 0);
    chk("overrun_outstanding", 64'(ovr_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/blob_tracker.md
BLOB_TRACKER -- requirements
Module: blob_tracker

Interface
REQ-001 SHALL have parameter PIX_W_UNUSED-free set, one per line: name, default, meaning.
REQ-002 H_ACTIVE, 640, active pixels per line.
REQ-003 V_ACTIVE, 480, active lines per frame.
REQ-004 N_CLASS, 2, number of independent colour classes tracked (1..8).
REQ-005 MIN_COUNT, 256, minimum pixels per frame for a class to count as "seen".
REQ-006 PERSIST, 3, consecutive seen frames required to assert detected (1..15).
REQ-007 ZONE_L / ZONE_R, 213 / 426, centroid x boundaries for left/centre/right.
REQ-008 Ports, one per line: name  direction  width  meaning.
REQ-009 clk  in  1  pixel clock (25 MHz VGA domain); single clock domain.
REQ-010 rst_n  in  1  asynchronous, active-low reset.
REQ-011 pixel_valid  in  1  high during active video (activeArea).
REQ-012 vsync  in  1  VGA vertical sync, active-low.
REQ-013 class_hit  in  N_CLASS  per-class pixel match for the current pixel (e.g. is_orange).
REQ-014 result_valid  out  1  one-cycle pulse when all class results update.
REQ-015 centroid_x  out  N_CLASS*X_W  per-class mean x of hit pixels, X_W=$clog2(H_ACTIVE).
REQ-016 pix_count  out  N_CLASS*CNT_W  per-class hit count, CNT_W=$clog2(H_ACTIVE*V_ACTIVE+1).
REQ-017 direction  out  N_CLASS*2  per class: 00 none, 01 left, 10 centre, 11 right.
REQ-018 detected  out  N_CLASS  per-class persistence-filtered detection flag.
REQ-019 overrun  out  1  one-cycle pulse when a frame end is dropped because the divider is busy.

Function
REQ-020 x counter SHALL increment per cycle with pixel_valid high, clear on pixel_valid falling edge, and saturate at H_ACTIVE-1 (excess pixels ignored).
REQ-021 Per class, count SHALL increment and sum_x (SUM_W=$clog2(H_ACTIVE*V_ACTIVE*H_ACTIVE)) SHALL add x on each cycle with pixel_valid and class_hit[i] both high.
REQ-022 Frame end SHALL be the vsync falling edge, detected via one registered sample of vsync.
REQ-023 On frame end in state IDLE: snapshot all count/sum_x, clear accumulators in the same cycle, go to DIVIDE with class index 0.
REQ-024 A hit on the frame-end cycle SHALL be lost (accumulators clear takes priority).
REQ-025 DIVIDE SHALL run a restoring divider, one quotient bit per cycle, SUM_W cycles per class, classes sequentially 0..N_CLASS-1.
REQ-026 Divisor zero SHALL yield quotient 0 without dividing (still SUM_W cycles, for fixed latency).
REQ-027 Quotient SHALL be truncated to X_W bits (always < H_ACTIVE by construction).
REQ-028 After the last class, state SHALL be UPDATE for one cycle: register all outputs, pulse result_valid, return to IDLE.
REQ-029 Frame-end to result_valid latency SHALL be exactly N_CLASS*SUM_W+2 cycles.
REQ-030 Frame end while in DIVIDE or UPDATE SHALL clear accumulators, pulse overrun, and not disturb the ongoing division.
REQ-031 seen[i] = snapshot count >= MIN_COUNT; direction SHALL be 00 if not seen, else 01 if centroid < ZONE_L, 11 if centroid >= ZONE_R, else 10.
REQ-032 Per class, a persistence counter SHALL increment (saturating at PERSIST) on a seen frame and clear on an unseen frame; detected[i] = counter == PERSIST.
REQ-033 All outputs SHALL hold between result_valid pulses.

Reset
REQ-034 rst_n low SHALL asynchronously clear all outputs, accumulators, snapshots, persistence counters, x counter, and return to IDLE.
REQ-035 The vsync sample register SHALL reset to 1 so no false frame end follows reset release.
REQ-036 Reset mid-DIVIDE SHALL abandon the computation with no result_valid.

Structure
REQ-037 State enum (IDLE, DIVIDE, UPDATE) and direction encoding constants SHALL live in shared package tracker_pkg.
REQ-038 The sequential divider SHALL be sub-module seq_divider (start/busy/done, parametrised SUM_W/CNT_W).

Verification
REQ-039 N_CLASS=1, 300 hits at x=100 -> after N_CLASS*SUM_W+2 cycles, result_valid, centroid 100, count 300, direction 01.
REQ-040 Hits at x=500 for 3 frames, count 400 -> detected rises on third result_valid, direction 11; one empty frame -> detected 0, direction 00.
REQ-041 Frame with 100 hits (< MIN_COUNT) at x=320 -> centroid 320, direction 00, persistence cleared.
REQ-042 Zero hits -> centroid 0, count 0, no divide-by-zero artefacts, latency unchanged.
REQ-043 Second vsync falling edge 10 cycles after first -> overrun pulse, first result correct, second frame's counts discarded.
REQ-044 rst_n asserted mid-DIVIDE -> outputs 0 immediately, no result_valid until a full new frame completes.
